mastermind_round_sequencer: RTL and testbench
=============================================

# mastermind_round_sequencer

Round-level controller for the Mastermind game datapath. It converts the raw load button level into single-cycle digit strobes, sequences code and guess entry, drives the four-position scoring engine (clear, four compare cycles, capture), counts guesses and decides win or loss. It sits between the board inputs (KEY/SW) and the code/guess registers plus scoring engine, replacing ad-hoc level-based load enables with a strobe/handshake scheme.

## Interface
- MAX_GUESSES, default 8: guesses allowed per game; legal range 1..15.
- clk  input  1  system clock (CLOCK_50).
- resetn  input  1  reset, synchronous, active-low.
- load  input  1  load request level, active-high, already synchronised to clk.
- new_game  input  1  restart request, active-high, sampled every cycle.
- red_in  input  3  red-peg total from the scoring engine.
- white_in  input  3  white-peg total from the scoring engine.
- load_code  output  4  one-hot code-digit write strobe; bit i writes code digit i.
- load_guess  output  4  one-hot guess-digit write strobe.
- score_clear  output  1  clears scoring-engine accumulators and matched flags.
- compare_en  output  1  scoring-engine step enable.
- compare_i  output  2  code position under comparison.
- red_out  output  3  latched red count of the last scored guess.
- white_out  output  3  latched white count of the last scored guess.
- guess_count  output  4  number of guesses scored this game.
- entry_idx  output  2  digit index the next load strobe will write.
- phase  output  2  0 = code entry, 1 = guess entry, 2 = scoring, 3 = game over.
- win  output  1  level; last guess scored red_in == 4.
- lose  output  1  level; MAX_GUESSES scored without a win.

## Operation
- Edge detect: load_q <= load every cycle. load_edge = load & ~load_q. Holding load high produces exactly one edge.
- States: CODE_ENTRY, GUESS_ENTRY, SC_CLEAR, SC_CMP, SC_CAPTURE, SC_CHECK, DONE. An internal 2-bit idx serves both entry and compare.
- CODE_ENTRY: on load_edge, pulse load_code[idx] and increment idx. Pulsing at idx 3 resets idx to 0 and moves to GUESS_ENTRY.
- GUESS_ENTRY: same as CODE_ENTRY, using load_guess. Pulsing at idx 3 moves to SC_CLEAR.
- SC_CLEAR: score_clear = 1 for one cycle, then SC_CMP with idx = 0.
- SC_CMP: compare_en = 1 and compare_i = idx for four consecutive cycles, idx 0..3, then SC_CAPTURE.
- SC_CAPTURE: red_out <= red_in, white_out <= white_in, guess_count <= guess_count + 1.
- SC_CHECK:
  - If red_out == 4: win <= 1, go to DONE.
  - Else if guess_count == MAX_GUESSES: lose <= 1, go to DONE.
  - Else: go to GUESS_ENTRY with idx 0.
- DONE: every load_edge is ignored. Only new_game or reset leaves DONE.
- new_game, in any state: go to CODE_ENTRY. idx, guess_count, red_out, white_out, win and lose are cleared. No strobe is issued that cycle. new_game beats a simultaneous load_edge.
- load_edge is ignored in SC_* and DONE. It is not queued.
- phase mapping: CODE_ENTRY = 0, GUESS_ENTRY = 1, SC_* = 2, DONE = 3. entry_idx = idx.
- win and lose are mutually exclusive; each stays asserted until new_game or reset.
- guess_count never exceeds MAX_GUESSES, so it does not wrap.

## Timing
- Reset values:
  - State CODE_ENTRY, idx 0.
  - All strobes, compare_en, compare_i, red_out, white_out, guess_count, win and lose are 0. phase is 0.
  - load_q resets to 1, so a load held through reset produces no strobe until it is released and pressed again.
- All outputs are registered.
- A load strobe is high for exactly one cycle, starting the cycle after the posedge that samples load_edge. The datapath captures SW on the posedge that ends the strobe.
- Scoring latency, from the cycle of the 4th load_guess strobe:
  - +1 score_clear
  - +2..+5 compare_i 0,1,2,3
  - +6 capture
  - +7 check
  - +8 phase = 1 or 3; win/lose visible.
- red_in and white_in must be valid in the SC_CAPTURE cycle. The scoring engine registers its totals on compare_en cycles.
- Reset mid-scoring: it is synchronous, so the sequence aborts immediately and no capture occurs.

## Test plan
- Reset with load held high, then release and press load 4 times (SW 1,2,3,4):
  - load_code strobes 0001, 0010, 0100, 1000, one cycle each.
  - phase = 1 and entry_idx = 0 afterwards.
- Hold load high for 50 cycles -> exactly one strobe is issued.
- Enter a guess and model red_in = 4 -> exact cycle sequence:
  - score_clear, then compare_i 0..3.
  - red_out = 4, guess_count = 1, win = 1, phase = 3.
  - A further load press produces no strobe.
- MAX_GUESSES = 3 with red_in = 1, white_in = 2 on every guess:
  - After guess 3: lose = 1, guess_count = 3, white_out = 2, phase = 3.
  - After guesses 1 and 2: phase returns to 1.
- Assert new_game in the same cycle as load_edge during GUESS_ENTRY idx 2:
  - No strobe is issued.
  - phase = 0, idx = 0, guess_count = 0.
- Pulse resetn low during SC_CMP with compare_i = 2:
  - Next cycle compare_en = 0 and all outputs are at their reset values.
  - red_out stays at 0.

Source files
------------

// File: rtl/mastermind_round_sequencer.sv
// Round controller for the Mastermind datapath: turns the load level into digit strobes,
// sequences code/guess entry, runs the four-cycle scoring engine and decides win or loss.
module mastermind_round_sequencer #(
  parameter int unsigned MAX_GUESSES = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic       new_game,
  input  logic [2:0] red_in,
  input  logic [2:0] white_in,
  output logic [3:0] load_code,
  output logic [3:0] load_guess,
  output logic       score_clear,
  output logic       compare_en,
  output logic [1:0] compare_i,
  output logic [2:0] red_out,
  output logic [2:0] white_out,
  output logic [3:0] guess_count,
  output logic [1:0] entry_idx,
  output logic [1:0] phase,
  output logic       win,
  output logic       lose
);

  typedef enum logic [2:0] {
    CODE_ENTRY  = 3'd0,
    GUESS_ENTRY = 3'd1,
    SC_CLEAR    = 3'd2,
    SC_CMP      = 3'd3,
    SC_CAPTURE  = 3'd4,
    SC_CHECK    = 3'd5,
    DONE        = 3'd6
  } state_t;

  localparam logic [3:0] MAX_G = 4'(MAX_GUESSES);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       load_q, load_d;
  logic [3:0] load_code_q, load_code_d;
  logic [3:0] load_guess_q, load_guess_d;
  logic       score_clear_q, score_clear_d;
  logic       compare_en_q, compare_en_d;
  logic [1:0] compare_i_q, compare_i_d;
  logic [2:0] red_q, red_d;
  logic [2:0] white_q, white_d;
  logic [3:0] guess_count_q, guess_count_d;
  logic [1:0] phase_q, phase_d;
  logic       win_q, win_d;
  logic       lose_q, lose_d;
  logic       load_edge;

  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      CODE_ENTRY:  phase_of = 2'd0;
      GUESS_ENTRY: phase_of = 2'd1;
      DONE:        phase_of = 2'd3;
      default:     phase_of = 2'd2;
    endcase
  endfunction

  assign load_edge = load & ~load_q;

  // Next-state and next-output logic; outputs are registered so they line up with state_q.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    load_d        = load;
    load_code_d   = 4'd0;
    load_guess_d  = 4'd0;
    red_d         = red_q;
    white_d       = white_q;
    guess_count_d = guess_count_q;
    win_d         = win_q;
    lose_d        = lose_q;
    if (new_game) begin
      state_d       = CODE_ENTRY;
      idx_d         = 2'd0;
      guess_count_d = 4'd0;
      red_d         = 3'd0;
      white_d       = 3'd0;
      win_d         = 1'b0;
      lose_d        = 1'b0;
    end else begin
      case (state_q)
        CODE_ENTRY: begin
          if (load_edge) begin
            load_code_d = 4'b0001 << idx_q;
            idx_d       = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_d = GUESS_ENTRY;
            end else begin
              state_d = CODE_ENTRY;
            end
          end else begin
            state_d = CODE_ENTRY;
          end
        end
        GUESS_ENTRY: begin
          // Leave one cycle after the last digit strobe so score_clear trails it by one.
          if (load_guess_q[3]) begin
            state_d = SC_CLEAR;
          end else if (load_edge) begin
            load_guess_d = 4'b0001 << idx_q;
            idx_d        = idx_q + 2'd1;
          end else begin
            state_d = GUESS_ENTRY;
          end
        end
        SC_CLEAR: begin
          state_d = SC_CMP;
          idx_d   = 2'd0;
        end
        SC_CMP: begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = SC_CAPTURE;
          end else begin
            state_d = SC_CMP;
          end
        end
        SC_CAPTURE: begin
          red_d         = red_in;
          white_d       = white_in;
          guess_count_d = guess_count_q + 4'd1;
          state_d       = SC_CHECK;
        end
        SC_CHECK: begin
          if (red_q == 3'd4) begin
            win_d   = 1'b1;
            state_d = DONE;
          end else if (guess_count_q == MAX_G) begin
            lose_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = GUESS_ENTRY;
            idx_d   = 2'd0;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = CODE_ENTRY;
          idx_d   = 2'd0;
        end
      endcase
    end
    score_clear_d = (state_d == SC_CLEAR);
    compare_en_d  = (state_d == SC_CMP);
    compare_i_d   = compare_en_d ? idx_d : 2'd0;
    phase_d       = phase_of(state_d);
  end

  // State and registered outputs; load_q resets high so a held button needs a fresh press.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= CODE_ENTRY;
      idx_q         <= 2'd0;
      load_q        <= 1'b1;
      load_code_q   <= 4'd0;
      load_guess_q  <= 4'd0;
      score_clear_q <= 1'b0;
      compare_en_q  <= 1'b0;
      compare_i_q   <= 2'd0;
      red_q         <= 3'd0;
      white_q       <= 3'd0;
      guess_count_q <= 4'd0;
      phase_q       <= 2'd0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      load_q        <= load_d;
      load_code_q   <= load_code_d;
      load_guess_q  <= load_guess_d;
      score_clear_q <= score_clear_d;
      compare_en_q  <= compare_en_d;
      compare_i_q   <= compare_i_d;
      red_q         <= red_d;
      white_q       <= white_d;
      guess_count_q <= guess_count_d;
      phase_q       <= phase_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
    end
  end

  assign load_code   = load_code_q;
  assign load_guess  = load_guess_q;
  assign score_clear = score_clear_q;
  assign compare_en  = compare_en_q;
  assign compare_i   = compare_i_q;
  assign red_out     = red_q;
  assign white_out   = white_q;
  assign guess_count = guess_count_q;
  assign entry_idx   = idx_q;
  assign phase       = phase_q;
  assign win         = win_q;
  assign lose        = lose_q;

endmodule

// File: tb/tb_mastermind_round_sequencer.sv
// Scoreboard bench for mastermind_round_sequencer: stimulus queues expected output events,
// a negedge monitor pops and compares them (with cycle gaps) as the DUT presents them.
module tb_mastermind_round_sequencer;

  localparam int MAXG = 3;

  logic       clk = 1'b0;
  logic       resetn, load, new_game;
  logic [2:0] red_in, white_in;
  logic [3:0] load_code, load_guess, guess_count;
  logic       score_clear, compare_en, win, lose;
  logic [1:0] compare_i, entry_idx, phase;
  logic [2:0] red_out, white_out;

  always #5 clk = ~clk;

  mastermind_round_sequencer #(.MAX_GUESSES(MAXG)) dut (
    .clk(clk), .resetn(resetn), .load(load), .new_game(new_game),
    .red_in(red_in), .white_in(white_in),
    .load_code(load_code), .load_guess(load_guess),
    .score_clear(score_clear), .compare_en(compare_en), .compare_i(compare_i),
    .red_out(red_out), .white_out(white_out), .guess_count(guess_count),
    .entry_idx(entry_idx), .phase(phase), .win(win), .lose(lose)
  );

  // kind: 0 load_code, 1 load_guess, 2 score_clear, 3 compare, 4 scoring result
  typedef struct {
    int          kind;
    logic [15:0] val;
    int          gap;   // required cycles since previous event, 0 = any
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_cyc = 0;

  task automatic expect_ev(input int kind, input logic [15:0] val, input int gap);
    ev_t e;
    e.kind = kind; e.val = val; e.gap = gap;
    exp_q.push_back(e);
  endtask

  function automatic logic [15:0] result_word(input logic [1:0] ph, input logic w, input logic l,
                                              input logic [3:0] cnt, input logic [2:0] r,
                                              input logic [2:0] wh);
    return {2'b00, ph, w, l, cnt, r, wh};
  endfunction

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  task automatic observe(input int kind, input logic [15:0] val);
    ev_t e;
    int  gap;
    gap = cyc - last_cyc;
    last_cyc = cyc;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d val=%h at cycle %0d, expected none", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || (e.gap != 0 && e.gap != gap)) begin
        errors++;
        $display("FAIL scoreboard: got kind=%0d val=%h gap=%0d, expected kind=%0d val=%h gap=%0d",
                 kind, val, gap, e.kind, e.val, e.gap);
      end
    end
  endtask

  // Monitor: every visible strobe/score event and every return from scoring is checked.
  initial begin
    logic [1:0] phase_prev;
    phase_prev = 2'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (load_code != 4'd0) observe(0, {12'd0, load_code});
      if (load_guess != 4'd0) observe(1, {12'd0, load_guess});
      if (score_clear) observe(2, 16'd0);
      if (compare_en) observe(3, {14'd0, compare_i});
      if (phase_prev == 2'd2 && (phase == 2'd1 || phase == 2'd3))
        observe(4, result_word(phase, win, lose, guess_count, red_out, white_out));
      phase_prev = phase;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    @(posedge clk); #1 load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
  endtask

  task automatic start_new_game();
    @(posedge clk); #1 new_game = 1'b1;
    @(posedge clk); #1 new_game = 1'b0;
  endtask

  task automatic code_entry();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 16'd1 << i;
      expect_ev(0, v, 0);
      press();
    end
  endtask

  task automatic guess_round(input logic [2:0] r, input logic [2:0] wh, input logic [1:0] ph,
                             input logic w, input logic l, input logic [3:0] cnt);
    logic [15:0] v;
    red_in = r; white_in = wh;
    for (int i = 0; i < 4; i++) begin
      v = 16'd1 << i;
      expect_ev(1, v, 0);
    end
    expect_ev(2, 16'd0, 1);
    for (int i = 0; i < 4; i++) expect_ev(3, 16'(i), 1);
    expect_ev(4, result_word(ph, w, l, cnt, r, wh), 3);
    for (int i = 0; i < 4; i++) press();
    wait_cycles(12);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_load_code"}, int'(load_code), 0);
    chk({tag, "_load_guess"}, int'(load_guess), 0);
    chk({tag, "_score_clear"}, int'(score_clear), 0);
    chk({tag, "_compare_en"}, int'(compare_en), 0);
    chk({tag, "_compare_i"}, int'(compare_i), 0);
    chk({tag, "_red_out"}, int'(red_out), 0);
    chk({tag, "_white_out"}, int'(white_out), 0);
    chk({tag, "_guess_count"}, int'(guess_count), 0);
    chk({tag, "_entry_idx"}, int'(entry_idx), 0);
    chk({tag, "_phase"}, int'(phase), 0);
    chk({tag, "_win"}, int'(win), 0);
    chk({tag, "_lose"}, int'(lose), 0);
  endtask

  initial begin
    bit found;
    logic [15:0] v;
    resetn = 1'b0; load = 1'b1; new_game = 1'b0; red_in = 3'd0; white_in = 3'd0;
    wait_cycles(3);
    check_reset_outputs("reset");

    // Load held through reset must not strobe until released and pressed again.
    resetn = 1'b1;
    wait_cycles(5);
    load = 1'b0;
    wait_cycles(2);
    code_entry();
    wait_cycles(2);
    chk("code_done_phase", int'(phase), 1);
    chk("code_done_idx", int'(entry_idx), 0);

    // Long hold: exactly one guess strobe.
    expect_ev(1, 16'd1, 0);
    @(posedge clk); #1 load = 1'b1;
    repeat (50) @(posedge clk);
    #1 load = 1'b0;
    wait_cycles(2);
    chk("hold_idx", int'(entry_idx), 1);

    // Finish this guess with a perfect score.
    red_in = 3'd4; white_in = 3'd0;
    for (int i = 1; i < 4; i++) begin
      v = 16'd1 << i;
      expect_ev(1, v, 0);
    end
    expect_ev(2, 16'd0, 1);
    for (int i = 0; i < 4; i++) expect_ev(3, 16'(i), 1);
    expect_ev(4, result_word(2'd3, 1'b1, 1'b0, 4'd1, 3'd4, 3'd0), 3);
    for (int i = 1; i < 4; i++) press();
    wait_cycles(12);
    press();
    wait_cycles(3);
    chk("win_phase_after_press", int'(phase), 3);
    chk("win_level", int'(win), 1);

    // Loss after MAXG guesses of red 1 / white 2.
    start_new_game();
    code_entry();
    guess_round(3'd1, 3'd2, 2'd1, 1'b0, 1'b0, 4'd1);
    guess_round(3'd1, 3'd2, 2'd1, 1'b0, 1'b0, 4'd2);
    guess_round(3'd1, 3'd2, 2'd3, 1'b0, 1'b1, 4'd3);
    chk("lose_level", int'(lose), 1);
    chk("lose_win_clear", int'(win), 0);

    // new_game collides with a load edge at guess idx 2.
    start_new_game();
    code_entry();
    guess_round(3'd0, 3'd0, 2'd1, 1'b0, 1'b0, 4'd1);
    expect_ev(1, 16'd1, 0);
    press();
    expect_ev(1, 16'd2, 0);
    press();
    wait_cycles(1);
    @(posedge clk); #1 load = 1'b1; new_game = 1'b1;
    @(posedge clk); #1 new_game = 1'b0;
    wait_cycles(2);
    chk("ng_phase", int'(phase), 0);
    chk("ng_idx", int'(entry_idx), 0);
    chk("ng_count", int'(guess_count), 0);
    chk("ng_red", int'(red_out), 0);
    load = 1'b0;
    wait_cycles(1);
    expect_ev(0, 16'd1, 0);
    press();
    wait_cycles(2);

    // Synchronous reset while compare_i = 2 aborts scoring with no capture.
    start_new_game();
    code_entry();
    red_in = 3'd3; white_in = 3'd1;
    for (int i = 0; i < 4; i++) begin
      v = 16'd1 << i;
      expect_ev(1, v, 0);
    end
    expect_ev(2, 16'd0, 1);
    for (int i = 0; i < 3; i++) expect_ev(3, 16'(i), 1);
    for (int i = 0; i < 4; i++) press();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (compare_en && compare_i == 2'd2) found = 1'b1;
    end
    chk("reach_compare_2", int'(found), 1);
    resetn = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midscore_reset");
    resetn = 1'b1;
    wait_cycles(10);
    chk("post_reset_red", int'(red_out), 0);
    chk("post_reset_count", int'(guess_count), 0);
    chk("post_reset_phase", int'(phase), 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
